// File: rtl/frame_update_scheduler_pkg.sv
// Shared constants and types for the frame-synchronous physics/render sequencer.
// Init positions are reused by the physics and graphics blocks.
package frame_update_scheduler_pkg;

    localparam logic [11:0] DEF_PAD_INIT     = 12'd240;
    localparam logic [11:0] DEF_BALL_X_INIT  = 12'd320;
    localparam logic [11:0] DEF_BALL_Y_INIT  = 12'd240;
    localparam int          DEF_FRAME_DIV    = 1;
    localparam int          DEF_STEP_TIMEOUT = 4096;

    typedef struct packed {
        logic [11:0] pad_left;
        logic [11:0] pad_right;
        logic [11:0] ball_x;
        logic [11:0] ball_y;
    } pos_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_update_scheduler_step_watchdog.sv
// Cycle counter bounding how long a physics step request may stay open.
// Holds at LIMIT-1 once expired until cleared.
module step_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/frame_update_scheduler.sv
// Issues a physics step every FRAME_DIV-th vblank and commits the returned
// positions to the renderer only while vblank is active.
module frame_update_scheduler
    import frame_update_scheduler_pkg::*;
#(
    parameter int          FRAME_DIV    = DEF_FRAME_DIV,
    parameter int          STEP_TIMEOUT = DEF_STEP_TIMEOUT,
    parameter logic [11:0] PAD_INIT     = DEF_PAD_INIT,
    parameter logic [11:0] BALL_X_INIT  = DEF_BALL_X_INIT,
    parameter logic [11:0] BALL_Y_INIT  = DEF_BALL_Y_INIT
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        vblank,
    input  logic        pause,
    output logic        step_req,
    input  logic        step_done,
    input  logic [11:0] nxt_pad_left,
    input  logic [11:0] nxt_pad_right,
    input  logic [11:0] nxt_ball_x,
    input  logic [11:0] nxt_ball_y,
    output logic [11:0] pad_left,
    output logic [11:0] pad_right,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [15:0] frame_cnt,
    output logic [7:0]  late_cnt,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_PEND   = 2'd3;

    localparam int DW = $clog2(FRAME_DIV + 1);

    localparam pos_t POS_INIT = '{
        pad_left:  PAD_INIT,
        pad_right: PAD_INIT,
        ball_x:    BALL_X_INIT,
        ball_y:    BALL_Y_INIT
    };

    logic [1:0]    state;
    logic          vb_q;
    logic [DW-1:0] div;
    pos_t          pos_q;
    pos_t          shadow;
    pos_t          nxt;

    logic vs_rise;
    logic div_last;
    logic eligible;
    logic expired;

    assign vs_rise  = vblank && !vb_q;
    assign div_last = (div == DW'(FRAME_DIV - 1));
    assign eligible = vs_rise && div_last;
    assign step_req = (state == S_REQ);

    assign nxt = '{
        pad_left:  nxt_pad_left,
        pad_right: nxt_pad_right,
        ball_x:    nxt_ball_x,
        ball_y:    nxt_ball_y
    };

    assign pad_left  = pos_q.pad_left;
    assign pad_right = pos_q.pad_right;
    assign ball_x    = pos_q.ball_x;
    assign ball_y    = pos_q.ball_y;

    step_watchdog #(
        .LIMIT(STEP_TIMEOUT)
    ) u_watchdog (
        .clk    (clk_vga),
        .rst_n  (rst),
        .clear  (state == S_IDLE),
        .enable (state == S_REQ),
        .expired(expired)
    );

    // vb_q resets high so releasing reset mid-vblank is not seen as a start
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            vb_q        <= 1'b1;
            div         <= '0;
            frame_cnt   <= '0;
            late_cnt    <= '0;
            timeout_cnt <= '0;
            pos_q       <= POS_INIT;
            shadow      <= POS_INIT;
        end else begin
            vb_q <= vblank;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
                div       <= div_last ? '0 : div + DW'(1);
            end
            unique case (state)
                S_IDLE: begin
                    if (eligible && !pause) state <= S_REQ;
                end
                S_REQ: begin
                    if (step_done) begin
                        shadow <= nxt;
                        if (vblank) begin
                            state <= S_COMMIT;
                        end else begin
                            state    <= S_PEND;
                            late_cnt <= sat_inc8(late_cnt);
                        end
                    end else if (expired) begin
                        timeout_cnt <= sat_inc8(timeout_cnt);
                        state       <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    // vblank may end exactly here; defer rather than tear
                    if (vblank) begin
                        pos_q <= shadow;
                        state <= S_IDLE;
                    end else begin
                        state    <= S_PEND;
                        late_cnt <= sat_inc8(late_cnt);
                    end
                end
                S_PEND: begin
                    if (vs_rise) begin
                        pos_q <= shadow;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: directed frames, expected
// steps and commits queued by stimulus, popped by monitors.
module tb_frame_update_scheduler;

    typedef struct packed {
        logic [11:0] pl;
        logic [11:0] pr;
        logic [11:0] bx;
        logic [11:0] by;
    } tpos_t;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        vblank;
    logic        pause;
    logic        step_done;
    logic [11:0] nxt_pad_left;
    logic [11:0] nxt_pad_right;
    logic [11:0] nxt_ball_x;
    logic [11:0] nxt_ball_y;
    logic        step_req;
    logic [11:0] pad_left;
    logic [11:0] pad_right;
    logic [11:0] ball_x;
    logic [11:0] ball_y;
    logic [15:0] frame_cnt;
    logic [7:0]  late_cnt;
    logic [7:0]  timeout_cnt;

    logic        d3_req;
    logic [11:0] d3_pl;
    logic [11:0] d3_pr;
    logic [11:0] d3_bx;
    logic [11:0] d3_by;
    logic [15:0] d3_frame;
    logic [7:0]  d3_late;
    logic [7:0]  d3_tmo;

    tpos_t exp_pos[$];
    int    exp_step[$];
    int    d3_steps[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_on = 1'b0;

    always #5 clk_vga = ~clk_vga;

    frame_update_scheduler #(
        .FRAME_DIV(1),
        .STEP_TIMEOUT(16)
    ) u_dut (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .vblank       (vblank),
        .pause        (pause),
        .step_req     (step_req),
        .step_done    (step_done),
        .nxt_pad_left (nxt_pad_left),
        .nxt_pad_right(nxt_pad_right),
        .nxt_ball_x   (nxt_ball_x),
        .nxt_ball_y   (nxt_ball_y),
        .pad_left     (pad_left),
        .pad_right    (pad_right),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .frame_cnt    (frame_cnt),
        .late_cnt     (late_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    // second instance with a divided step rate; physics answers at once
    frame_update_scheduler #(
        .FRAME_DIV(3),
        .STEP_TIMEOUT(16)
    ) u_div3 (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .vblank       (vblank),
        .pause        (1'b0),
        .step_req     (d3_req),
        .step_done    (d3_req),
        .nxt_pad_left (12'd7),
        .nxt_pad_right(12'd8),
        .nxt_ball_x   (12'd9),
        .nxt_ball_y   (12'd10),
        .pad_left     (d3_pl),
        .pad_right    (d3_pr),
        .ball_x       (d3_bx),
        .ball_y       (d3_by),
        .frame_cnt    (d3_frame),
        .late_cnt     (d3_late),
        .timeout_cnt  (d3_tmo)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_vga);
            #1;
        end
    endtask

    task automatic set_nxt(input int pl, input int pr, input int bx, input int by);
        nxt_pad_left  = 12'(pl);
        nxt_pad_right = 12'(pr);
        nxt_ball_x    = 12'(bx);
        nxt_ball_y    = 12'(by);
    endtask

    function automatic tpos_t mk(input int pl, input int pr, input int bx, input int by);
        return {12'(pl), 12'(pr), 12'(bx), 12'(by)};
    endfunction

    // monitor: step requests and position commits
    initial begin
        logic  prev_req;
        tpos_t prev;
        tpos_t cur;
        tpos_t e;
        int    f;
        wait (mon_on);
        @(negedge clk_vga);
        prev_req = step_req;
        prev = {pad_left, pad_right, ball_x, ball_y};
        forever begin
            @(negedge clk_vga);
            cur = {pad_left, pad_right, ball_x, ball_y};
            if (step_req && !prev_req) begin
                checks++;
                if (exp_step.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: frame_cnt=%0d, none expected", frame_cnt);
                end else begin
                    f = exp_step.pop_front();
                    if (int'(frame_cnt) != f) begin
                        errors++;
                        $display("FAIL step_frame: got %0d expected %0d", frame_cnt, f);
                    end
                end
            end
            if (cur != prev) begin
                checks++;
                if (rst && !vblank) begin
                    errors++;
                    $display("FAIL commit_outside_vblank: pos=%h", cur);
                end
                checks++;
                if (exp_pos.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit: pos=%h", cur);
                end else begin
                    e = exp_pos.pop_front();
                    if (cur != e) begin
                        errors++;
                        $display("FAIL commit_value: got %h expected %h", cur, e);
                    end
                end
            end
            prev = cur;
            prev_req = step_req;
        end
    end

    initial begin
        logic p;
        p = 1'b0;
        forever begin
            @(negedge clk_vga);
            if (d3_req && !p) d3_steps.push_back(int'(d3_frame));
            p = d3_req;
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        vblank = 1'b1;
        pause = 1'b0;
        step_done = 1'b0;
        set_nxt(0, 0, 0, 0);
        tick(3);
        chk("rst_pad_left", pad_left, 240);
        chk("rst_pad_right", pad_right, 240);
        chk("rst_ball_x", ball_x, 320);
        chk("rst_ball_y", ball_y, 240);
        chk("rst_step_req", step_req, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_late_cnt", late_cnt, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        rst = 1'b1;
        tick(4);
        chk("no_false_start_req", step_req, 0);
        chk("no_false_start_frame", frame_cnt, 0);
        mon_on = 1'b1;
        tick(1);

        // normal step, frame 1
        vblank = 1'b0;
        tick(5);
        vblank = 1'b1;
        exp_step.push_back(1);
        tick(1);
        chk("norm_req_t1", step_req, 1);
        tick(3);
        chk("norm_req_t4", step_req, 1);
        tick(1);
        chk("norm_req_t5", step_req, 1);
        step_done = 1'b1;
        set_nxt(100, 200, 300, 400);
        exp_pos.push_back(mk(100, 200, 300, 400));
        tick(1);
        step_done = 1'b0;
        chk("norm_req_t6", step_req, 0);
        chk("norm_ball_x_t6", ball_x, 320);
        tick(1);
        chk("norm_pad_left", pad_left, 100);
        chk("norm_pad_right", pad_right, 200);
        chk("norm_ball_x", ball_x, 300);
        chk("norm_ball_y", ball_y, 400);
        chk("norm_frame_cnt", frame_cnt, 1);
        tick(2);

        // late result, frame 2; commit on frame 3
        vblank = 1'b0;
        tick(5);
        vblank = 1'b1;
        exp_step.push_back(2);
        tick(3);
        vblank = 1'b0;
        tick(2);
        step_done = 1'b1;
        set_nxt(110, 210, 50, 410);
        exp_pos.push_back(mk(110, 210, 50, 410));
        tick(1);
        step_done = 1'b0;
        chk("late_cnt", late_cnt, 1);
        chk("late_req_low", step_req, 0);
        tick(10);
        chk("late_ball_x_held", ball_x, 300);
        vblank = 1'b1;
        tick(1);
        chk("late_ball_x_commit", ball_x, 50);
        chk("late_pad_left_commit", pad_left, 110);
        tick(2);

        // timeout, frame 4
        vblank = 1'b0;
        tick(3);
        vblank = 1'b1;
        exp_step.push_back(4);
        tick(1);
        n = 0;
        while (step_req && n < 40) begin
            n++;
            tick(1);
        end
        chk("timeout_req_cycles", n, 16);
        chk("timeout_cnt", timeout_cnt, 1);
        chk("timeout_ball_x_held", ball_x, 50);
        tick(3);

        // next eligible frame 5 issues a fresh step
        vblank = 1'b0;
        tick(3);
        vblank = 1'b1;
        exp_step.push_back(5);
        tick(2);
        step_done = 1'b1;
        set_nxt(1, 2, 3, 4);
        exp_pos.push_back(mk(1, 2, 3, 4));
        tick(1);
        step_done = 1'b0;
        tick(1);
        chk("after_to_pad_left", pad_left, 1);
        chk("after_to_ball_y", ball_y, 4);
        tick(2);

        // paused frames 6..9 with stray step_done
        vblank = 1'b0;
        pause = 1'b1;
        step_done = 1'b1;
        set_nxt(999, 999, 999, 999);
        tick(3);
        repeat (4) begin
            vblank = 1'b1;
            tick(3);
            vblank = 1'b0;
            tick(3);
        end
        step_done = 1'b0;
        pause = 1'b0;
        chk("pause_frame_cnt", frame_cnt, 9);
        chk("stray_done_ignored", pad_left, 1);

        // divide-by-3 instance over the same 9 frames
        chk("div3_step_count", d3_steps.size(), 3);
        for (int i = 0; i < d3_steps.size() && i < 3; i++)
            chk("div3_step_frame", d3_steps[i], 3 * (i + 1));
        chk("div3_frame_cnt", d3_frame, 9);

        // asynchronous reset during a step
        vblank = 1'b1;
        exp_step.push_back(10);
        tick(2);
        chk("mid_req_open", step_req, 1);
        exp_pos.push_back(mk(240, 240, 320, 240));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", step_req, 0);
        chk("mid_rst_pad_left", pad_left, 240);
        chk("mid_rst_ball_x", ball_x, 320);
        step_done = 1'b1;
        set_nxt(77, 77, 77, 77);
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("post_rst_req", step_req, 0);
        chk("post_rst_ball_x", ball_x, 320);
        chk("post_rst_frame_cnt", frame_cnt, 0);
        step_done = 1'b0;
        tick(2);

        chk("steps_drained", exp_step.size(), 0);
        chk("commits_drained", exp_pos.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
